// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
//   PS/2 keyboard receiver and scan-code decoder, fully synchronous to clk.
//   Raw ps2_clk/ps2_data are synchronised. The receiver captures 11-bit
//   frames: a start bit, 8 data bits LSB first, odd parity, and a stop bit.
//   It checks parity, the stop bit and an inactivity timeout. E0 (extended)
//   and F0 (break) prefixes are folded into each key event. Events are
//   queued in a first-word-fall-through FIFO with a valid/ready handshake.
//   A held-bitmask and a "last make" code are kept for NUM_KEYS game keys.
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-low; clears all state
//   ps2_clk        raw PS/2 clock (asynchronous)
//   ps2_data       raw PS/2 data (asynchronous)
//   ev_data        {break, extended, code[7:0]} at the FIFO head (0 when empty)
//   ev_valid       FIFO non-empty
//   ev_ready       consumer ready; an entry is popped when ev_valid & ev_ready
//   keys_held      bit i set while game key i is pressed
//   keyboard_input {8'h00, code} of the last mapped make; 0 once it is released
//   frame_err      one-cycle pulse on a parity, stop or timeout error
//   overflow       one-cycle pulse when an event is dropped (FIFO full)
//   fifo_count     number of entries held in the FIFO
// ---------------------------------------------------------------------------
module ps2_key_decoder #(
  parameter int                    SYNC_STAGES    = 2,
  parameter int                    TIMEOUT_CYCLES = 50000,
  parameter int                    FIFO_DEPTH     = 8,
  parameter int                    NUM_KEYS       = 3,
  parameter logic [8*NUM_KEYS-1:0] KEY_CODES      = 24'h29_23_1C
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [9:0]                    ev_data,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [NUM_KEYS-1:0]           keys_held,
  output logic [15:0]                   keyboard_input,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0]       CODE_E0  = 8'hE0;
  localparam logic [7:0]       CODE_F0  = 8'hF0;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

  // Synchronisers and fall detection. The synchronisers reset to 1, which is
  // the idle level of the bus. This keeps reset release from looking like a
  // clock fall.
  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  logic                   clk_s, data_s, fall;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall   = clk_prev & ~clk_s;

  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_s;
    end
  end

  // Receiver state
  state_t          state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            parity_bit;
  logic [TO_W-1:0] to_cnt;
  logic            ext_flag, brk_flag;
  logic [7:0]      kb_code;

  logic                frame_ok, stop_fall, push, pop, full, wr_en;
  logic [NUM_KEYS-1:0] key_hit;

  // On the stop-bit fall, shreg/parity_bit hold the completed frame.
  assign stop_fall = fall && (state == ST_STOP);
  assign frame_ok  = data_s && (^{shreg, parity_bit});
  assign push      = stop_fall && frame_ok && (shreg != CODE_E0) && (shreg != CODE_F0);

  // NOTE: combinational outputs get a default before any conditional
  // assignment, so no path leaves them unassigned (no latch).
  always_comb begin
    key_hit = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      key_hit[i] = (shreg == KEY_CODES[8*i +: 8]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      parity_bit <= 1'b0;
      to_cnt     <= '0;
      frame_err  <= 1'b0;
      ext_flag   <= 1'b0;
      brk_flag   <= 1'b0;
      keys_held  <= '0;
      kb_code    <= '0;
    end else begin
      frame_err <= 1'b0;

      // Inactivity counter: restarts on every fall and runs only while a
      // frame is open.
      if (fall || state == ST_IDLE) to_cnt <= '0;
      else                          to_cnt <= to_cnt + 1'b1;

      if (fall) begin
        case (state)
          ST_IDLE: begin
            // A fall with data high is a line glitch, not a start bit.
            if (!data_s) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shreg   <= {data_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            parity_bit <= data_s;
            state      <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (!frame_ok) begin
              frame_err <= 1'b1;
              ext_flag  <= 1'b0;
              brk_flag  <= 1'b0;
            end else if (shreg == CODE_E0) begin
              ext_flag <= 1'b1;
            end else if (shreg == CODE_F0) begin
              brk_flag <= 1'b1;
            end else begin
              ext_flag <= 1'b0;
              brk_flag <= 1'b0;
              // Extended codes share scan values with game keys but are
              // different physical keys, so they never touch the key map.
              if (!ext_flag) begin
                for (int i = 0; i < NUM_KEYS; i++) begin
                  if (key_hit[i]) keys_held[i] <= ~brk_flag;
                end
                if (|key_hit) begin
                  if (!brk_flag)             kb_code <= shreg;
                  else if (kb_code == shreg) kb_code <= '0;
                end
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE && to_cnt == TO_LAST) begin
        // Abort the open frame. The prefix flags survive, so a later good
        // byte still sees a prefix received before the stall.
        frame_err <= 1'b1;
        state     <= ST_IDLE;
        shreg     <= '0;
      end
    end
  end

  assign keyboard_input = {8'h00, kb_code};

  // Event FIFO (first-word-fall-through)
  logic [9:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  assign ev_valid   = (count != '0);
  assign full       = (count == FULL_CNT);
  assign pop        = ev_valid && ev_ready;
  assign wr_en      = push && (!full || pop);
  assign fifo_count = count;
  assign ev_data    = ev_valid ? mem[rd_ptr] : 10'h000;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // Power-of-two depth: the pointers wrap by natural overflow.
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overflow <= push && full && !pop;
    end
  end

  // NOTE: the storage array has no reset. Entries are only observable once
  // written, and ev_data is gated by ev_valid, so stale contents never
  // leave the block.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {brk_flag, ext_flag, shreg};
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_decoder
//   Directed bench for ps2_key_decoder.
//   A table of single-byte frames is applied in order. Each row lists the
//   event it must produce, the key state and keyboard_input after it, and
//   whether it raises a frame error. Hand-written sequences cover the
//   timeout, an idle glitch, FIFO overflow and reset mid-frame.
// ---------------------------------------------------------------------------
module tb_ps2_key_decoder;

  localparam int TO   = 200;
  localparam int HALF = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [9:0]  ev_data;
  logic        ev_valid;
  logic        ev_ready = 1'b1;
  logic [2:0]  keys_held;
  logic [15:0] keyboard_input;
  logic        frame_err;
  logic        overflow;
  logic [3:0]  fifo_count;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .ps2_clk        (ps2_clk),
    .ps2_data       (ps2_data),
    .ev_data        (ev_data),
    .ev_valid       (ev_valid),
    .ev_ready       (ev_ready),
    .keys_held      (keys_held),
    .keyboard_input (keyboard_input),
    .frame_err      (frame_err),
    .overflow       (overflow),
    .fifo_count     (fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int ovf_pulses = 0;
  logic [9:0] evq[$];

  always @(posedge clk) begin
    if (frame_err) err_pulses++;
    if (overflow)  ovf_pulses++;
  end

  // Record each event as it is popped on the coming rising edge.
  always @(negedge clk) begin
    if (ev_valid && ev_ready) evq.push_back(ev_data);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic bad_stop);
    logic [10:0] f;
    f = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
    send_bits(f, 11);
    ps2_data = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  code;
    logic        bad_par;
    logic        bad_stop;
    int          exp_ev;
    logic [9:0]  exp_data;
    logic [2:0]  exp_keys;
    logic [15:0] exp_kb;
    int          exp_err;
  } vec_t;

  vec_t vecs[22];

  initial begin
    int n0, e0, o0;

    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, e0, o0;

    vecs[0]  = '{8'h1C, 1'b0, 1'b0, 1, 10'h01C, 3'b001, 16'h001C, 0};
    vecs[1]  = '{8'hF0, 1'b0, 1'b0, 0, 10'h000, 3'b001, 16'h001C, 0};
    vecs[2]  = '{8'h1C, 1'b0, 1'b0, 1, 10'h21C, 3'b000, 16'h0000, 0};
    vecs[3]  = '{8'hE0, 1'b0, 1'b0, 0, 10'h000, 3'b000, 16'h0000, 0};
    vecs[4]  = '{8'h6B, 1'b0, 1'b0, 1, 10'h16B, 3'b000, 16'h0000, 0};
    vecs[5]  = '{8'hE0, 1'b0, 1'b0, 0, 10'h000, 3'b000, 16'h0000, 0};
    vecs[6]  = '{8'hF0, 1'b0, 1'b0, 0, 10'h000, 3'b000, 16'h0000, 0};
    vecs[7]  = '{8'h6B, 1'b0, 1'b0, 1, 10'h36B, 3'b000, 16'h0000, 0};
    vecs[8]  = '{8'h29, 1'b0, 1'b0, 1, 10'h029, 3'b100, 16'h0029, 0};
    vecs[9]  = '{8'h1C, 1'b1, 1'b0, 0, 10'h000, 3'b100, 16'h0029, 1};
    vecs[10] = '{8'hF0, 1'b0, 1'b0, 0, 10'h000, 3'b100, 16'h0029, 0};
    vecs[11] = '{8'h1C, 1'b1, 1'b0, 0, 10'h000, 3'b100, 16'h0029, 1};
    vecs[12] = '{8'h29, 1'b0, 1'b0, 1, 10'h029, 3'b100, 16'h0029, 0};
    vecs[13] = '{8'h23, 1'b0, 1'b0, 1, 10'h023, 3'b110, 16'h0023, 0};
    vecs[14] = '{8'hF0, 1'b0, 1'b0, 0, 10'h000, 3'b110, 16'h0023, 0};
    vecs[15] = '{8'h29, 1'b0, 1'b0, 1, 10'h229, 3'b010, 16'h0023, 0};
    vecs[16] = '{8'hE0, 1'b0, 1'b0, 0, 10'h000, 3'b010, 16'h0023, 0};
    vecs[17] = '{8'h1C, 1'b0, 1'b0, 1, 10'h11C, 3'b010, 16'h0023, 0};
    vecs[18] = '{8'h15, 1'b0, 1'b0, 1, 10'h015, 3'b010, 16'h0023, 0};
    vecs[19] = '{8'hF0, 1'b0, 1'b0, 0, 10'h000, 3'b010, 16'h0023, 0};
    vecs[20] = '{8'h23, 1'b0, 1'b0, 1, 10'h223, 3'b000, 16'h0000, 0};
    vecs[21] = '{8'h1C, 1'b0, 1'b1, 0, 10'h000, 3'b000, 16'h0000, 1};

    // Reset state
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_ev_valid", 32'(ev_valid), 32'd0);
    check("rst_ev_data", 32'(ev_data), 32'h0);
    check("rst_keys", 32'(keys_held), 32'h0);
    check("rst_kb", 32'(keyboard_input), 32'h0);
    check("rst_count", 32'(fifo_count), 32'h0);
    check("rst_err_ovf", 32'({frame_err, overflow}), 32'h0);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("post_rst_count", 32'(fifo_count), 32'h0);

    // Table-driven frames
    for (int v = 0; v < 22; v++) begin
      n0 = evq.size();
      e0 = err_pulses;
      send_frame(vecs[v].code, vecs[v].bad_par, vecs[v].bad_stop);
      check($sformatf("v%0d_ev_count", v), 32'(evq.size() - n0), 32'(vecs[v].exp_ev));
      if (vecs[v].exp_ev != 0 && evq.size() > n0)
        check($sformatf("v%0d_ev_data", v), 32'(evq[n0]), 32'(vecs[v].exp_data));
      check($sformatf("v%0d_keys", v), 32'(keys_held), 32'(vecs[v].exp_keys));
      check($sformatf("v%0d_kb", v), 32'(keyboard_input), 32'(vecs[v].exp_kb));
      check($sformatf("v%0d_err", v), 32'(err_pulses - e0), 32'(vecs[v].exp_err));
    end

    // Timeout after 4 data bits, then a good 23
    n0 = evq.size();
    e0 = err_pulses;
    send_bits(11'b000_0000_0000, 5);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("to_no_early_err", 32'(err_pulses - e0), 32'd0);
    repeat (TO + 20) @(posedge clk);
    @(negedge clk);
    check("to_err", 32'(err_pulses - e0), 32'd1);
    check("to_no_event", 32'(evq.size() - n0), 32'd0);
    send_frame(8'h23, 1'b0, 1'b0);
    check("to_next_keys", 32'(keys_held), 32'b010);
    check("to_next_kb", 32'(keyboard_input), 32'h0023);
    check("to_next_ev_count", 32'(evq.size() - n0), 32'd1);
    if (evq.size() > n0) check("to_next_ev", 32'(evq[n0]), 32'h023);

    // F0 survives a timeout
    send_frame(8'hF0, 1'b0, 1'b0);
    e0 = err_pulses;
    send_bits(11'b000_0000_0000, 5);
    repeat (TO + 40) @(posedge clk);
    @(negedge clk);
    check("to2_err", 32'(err_pulses - e0), 32'd1);
    n0 = evq.size();
    send_frame(8'h23, 1'b0, 1'b0);
    check("to2_ev_count", 32'(evq.size() - n0), 32'd1);
    if (evq.size() > n0) check("to2_ev", 32'(evq[n0]), 32'h223);
    check("to2_keys", 32'(keys_held), 32'b000);

    // Idle glitch: fall with data high is ignored
    e0 = err_pulses;
    n0 = evq.size();
    ps2_data = 1'b1;
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("glitch_err", 32'(err_pulses - e0), 32'd0);
    check("glitch_count", 32'(fifo_count), 32'd0);
    send_frame(8'h1C, 1'b0, 1'b0);
    check("glitch_next_ev_count", 32'(evq.size() - n0), 32'd1);
    if (evq.size() > n0) check("glitch_next_ev", 32'(evq[n0]), 32'h01C);
    check("glitch_next_keys", 32'(keys_held), 32'b001);

    // Overflow: 9 makes into an 8-deep FIFO with no pops
    @(negedge clk);
    ev_ready = 1'b0;
    o0 = ovf_pulses;
    n0 = evq.size();
    for (int i = 0; i < 9; i++) send_frame(8'h40 + 8'(i), 1'b0, 1'b0);
    check("ovf_count", 32'(fifo_count), 32'd8);
    check("ovf_pulse", 32'(ovf_pulses - o0), 32'd1);
    check("ovf_valid", 32'(ev_valid), 32'd1);
    check("ovf_head", 32'(ev_data), 32'h040);
    repeat (7) @(negedge clk);
    check("ovf_head_stable", 32'(ev_data), 32'h040);
    ev_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("ovf_pops", 32'(evq.size() - n0), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (evq.size() > n0 + i)
        check($sformatf("ovf_order%0d", i), 32'(evq[n0 + i]), 32'h40 + 32'(i));
    end
    check("ovf_drained", 32'(fifo_count), 32'd0);
    check("ovf_empty_valid", 32'(ev_valid), 32'd0);

    // Reset in the middle of a frame
    e0 = err_pulses;
    send_bits(11'b000_0000_0000, 4);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_keys", 32'(keys_held), 32'h0);
    check("mid_rst_kb", 32'(keyboard_input), 32'h0);
    check("mid_rst_count", 32'(fifo_count), 32'h0);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    reset = 1'b1;
    n0 = evq.size();
    repeat (TO + 20) @(negedge clk);
    check("mid_rst_no_err", 32'(err_pulses - e0), 32'd0);
    check("mid_rst_no_event", 32'(evq.size() - n0), 32'd0);
    send_frame(8'h1C, 1'b0, 1'b0);
    check("mid_rst_next_count", 32'(evq.size() - n0), 32'd1);
    if (evq.size() > n0) check("mid_rst_next_ev", 32'(evq[n0]), 32'h01C);
    check("mid_rst_next_keys", 32'(keys_held), 32'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
